// File: rtl/apple1_pia.sv
// Apple-1 PIA keyboard/display register window ($D010-$D013).
// Define APPLE1_PIA_KBD_FIFO_EN to replace the single key latch with a FIFO_DEPTH-entry FIFO.
module apple1_pia #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       cs,
    input  logic [1:0] addr,
    input  logic       we,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [6:0] kbd_data,
    input  logic       kbd_strobe,
    output logic [6:0] disp_data,
    output logic       disp_valid,
    input  logic       disp_ready
);

    localparam logic [1:0] REG_KBD   = 2'd0;
    localparam logic [1:0] REG_KBDCR = 2'd1;
    localparam logic [1:0] REG_DSP   = 2'd2;
    localparam logic [1:0] REG_DSPCR = 2'd3;

    logic       acc;
    logic       wr_dsp, wr_kcr, wr_dcr, rd_kbd;
    logic [6:0] key_in;
    logic [6:0] head_key;
    logic       kbd_flag;

    logic [6:0] kcr_q, kcr_d;
    logic [6:0] dcr_q, dcr_d;
    logic [6:0] disp_data_q, disp_data_d;
    logic       disp_valid_q, disp_valid_d;

    assign acc    = enable & cs;
    assign wr_dsp = acc & we & (addr == REG_DSP);
    assign wr_kcr = acc & we & (addr == REG_KBDCR);
    assign wr_dcr = acc & we & (addr == REG_DSPCR);
    assign rd_kbd = acc & ~we & (addr == REG_KBD);

    // Lowercase letters are folded to uppercase before storage.
    always_comb begin
        key_in = kbd_data;
        if (kbd_data >= 7'h61 && kbd_data <= 7'h7A) key_in = kbd_data - 7'h20;
    end

`ifdef APPLE1_PIA_KBD_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [6:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]  last_q, last_d;
    logic        empty, full, push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = rd_kbd & ~empty;
    // A full FIFO still accepts a key when an entry leaves on the same edge.
    assign push  = kbd_strobe & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
            if (push) mem_q[wr_ptr_q[AW-1:0]] <= key_in;
        end
    end

    // An empty FIFO keeps presenting the most recently popped key.
    assign head_key = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];
    assign kbd_flag = ~empty;
`else
    logic [6:0] key_q, key_d;
    logic       flag_q, flag_d;

    // A strobe coinciding with a KBD read keeps the flag set for the new key.
    always_comb begin
        key_d  = key_q;
        flag_d = flag_q;
        if (rd_kbd) flag_d = 1'b0;
        if (kbd_strobe) begin
            key_d  = key_in;
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            key_q  <= key_d;
            flag_q <= flag_d;
        end
    end

    assign head_key = key_q;
    assign kbd_flag = flag_q;
`endif

    // A DSP write on a transfer edge wins and keeps the character pending.
    always_comb begin
        kcr_d        = kcr_q;
        dcr_d        = dcr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        if (disp_valid_q && disp_ready) disp_valid_d = 1'b0;
        if (wr_dsp) begin
            disp_data_d  = din[6:0];
            disp_valid_d = 1'b1;
        end
        if (wr_kcr) kcr_d = din[6:0];
        if (wr_dcr) dcr_d = din[6:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kcr_q        <= '0;
            dcr_q        <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            kcr_q        <= kcr_d;
            dcr_q        <= dcr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    always_comb begin
        dout = 8'h00;
        if (cs) begin
            case (addr)
                REG_KBD:   dout = {1'b1, head_key};
                REG_KBDCR: dout = {kbd_flag, kcr_q};
                REG_DSP:   dout = {disp_valid_q, disp_data_q};
                default:   dout = {1'b0, dcr_q};
            endcase
        end
    end

    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_apple1_pia.sv
// Directed bench for apple1_pia: register map, key folding, display handshake, same-edge cases.
module tb_apple1_pia;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cs;
    logic [1:0] addr;
    logic       we;
    logic [7:0] din;
    logic [7:0] dout;
    logic [6:0] kbd_data;
    logic       kbd_strobe;
    logic [6:0] disp_data;
    logic       disp_valid;
    logic       disp_ready;

    int checks   = 0;
    int failures = 0;

    apple1_pia #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cs         (cs),
        .addr       (addr),
        .we         (we),
        .din        (din),
        .dout       (dout),
        .kbd_data   (kbd_data),
        .kbd_strobe (kbd_strobe),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready)
    );

    always #5 clk = ~clk;

    task automatic idle();
        enable = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00;
        kbd_strobe = 1'b0; kbd_data = 7'h00;
    endtask

    // Bus read: dout sampled before the edge, side effect applied on the edge.
    task automatic read_reg(input logic [1:0] a, input logic en, output logic [7:0] data);
        enable = en; cs = 1'b1; we = 1'b0; addr = a;
        #1 data = dout;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        enable = 1'b1; cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic strobe_key(input logic [6:0] k);
        kbd_data = k; kbd_strobe = 1'b1;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_reset();
        logic [7:0] exp_rd [4];
        logic [7:0] got;
        exp_rd[0] = 8'h80; exp_rd[1] = 8'h00; exp_rd[2] = 8'h00; exp_rd[3] = 8'h00;
        idle(); disp_ready = 1'b0; reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (disp_valid !== 1'b0) begin
            $display("FAIL reset_disp_valid got=%b exp=0", disp_valid); failures++;
        end
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), 1'b1, got);
            checks++;
            if (got !== exp_rd[i]) begin
                $display("FAIL reset_read_reg%0d got=%h exp=%h", i, got, exp_rd[i]); failures++;
            end
        end
        cs = 1'b0; addr = 2'd0; #1;
        checks++;
        if (dout !== 8'h00) begin
            $display("FAIL cs_low_dout got=%h exp=00", dout); failures++;
        end
    endtask

    task automatic test_keyboard();
        logic [7:0] got;
        strobe_key(7'h61);
        read_reg(2'd1, 1'b1, got);
        checks++;
        if (got !== 8'h80) begin $display("FAIL kbdcr_after_a got=%h exp=80", got); failures++; end
        read_reg(2'd0, 1'b1, got);
        checks++;
        if (got !== 8'hC1) begin $display("FAIL kbd_a_folded got=%h exp=C1", got); failures++; end
        read_reg(2'd1, 1'b1, got);
        checks++;
        if (got !== 8'h00) begin $display("FAIL kbdcr_cleared got=%h exp=00", got); failures++; end

        // 'z' folds to 'Z'; a read with enable low must not consume it.
        strobe_key(7'h7A);
        read_reg(2'd0, 1'b0, got);
        checks++;
        if (got !== 8'hDA) begin $display("FAIL kbd_z_folded got=%h exp=DA", got); failures++; end
        read_reg(2'd1, 1'b1, got);
        checks++;
        if (got !== 8'h80) begin $display("FAIL kbd_read_no_enable got=%h exp=80", got); failures++; end
        write_reg(2'd1, 8'hD5);
        read_reg(2'd1, 1'b1, got);
        checks++;
        if (got !== 8'hD5) begin $display("FAIL kbdcr_write_flag got=%h exp=D5", got); failures++; end
        write_reg(2'd0, 8'h00);
        read_reg(2'd0, 1'b1, got);
        checks++;
        if (got !== 8'hDA) begin $display("FAIL kbd_write_ignored got=%h exp=DA", got); failures++; end
        read_reg(2'd1, 1'b1, got);
        checks++;
        if (got !== 8'h55) begin $display("FAIL kbdcr_after_pop got=%h exp=55", got); failures++; end
        write_reg(2'd1, 8'h00);

        // Codes just outside the lowercase range are stored unchanged.
        strobe_key(7'h7B);
        read_reg(2'd0, 1'b1, got);
        checks++;
        if (got !== 8'hFB) begin $display("FAIL kbd_brace_unfolded got=%h exp=FB", got); failures++; end
        strobe_key(7'h60);
        read_reg(2'd0, 1'b1, got);
        checks++;
        if (got !== 8'hE0) begin $display("FAIL kbd_backtick_unfolded got=%h exp=E0", got); failures++; end
    endtask

    task automatic test_kbd_same_edge();
        logic [7:0] got;
        strobe_key(7'h41);
        enable = 1'b1; cs = 1'b1; we = 1'b0; addr = 2'd0;
        kbd_data = 7'h42; kbd_strobe = 1'b1;
        @(posedge clk); #1;
        idle();
        read_reg(2'd1, 1'b1, got);
        checks++;
        if (got !== 8'h80) begin $display("FAIL same_edge_kbdcr got=%h exp=80", got); failures++; end
        read_reg(2'd0, 1'b1, got);
        checks++;
        if (got !== 8'hC2) begin $display("FAIL same_edge_kbd got=%h exp=C2", got); failures++; end
        read_reg(2'd1, 1'b1, got);
        checks++;
        if (got !== 8'h00) begin $display("FAIL same_edge_drained got=%h exp=00", got); failures++; end
    endtask

`ifndef APPLE1_PIA_KBD_FIFO_EN
    task automatic test_latch_overwrite();
        logic [7:0] got;
        strobe_key(7'h58);
        strobe_key(7'h79);
        read_reg(2'd0, 1'b1, got);
        checks++;
        if (got !== 8'hD9) begin $display("FAIL latch_overwrite got=%h exp=D9", got); failures++; end
        read_reg(2'd1, 1'b1, got);
        checks++;
        if (got !== 8'h00) begin $display("FAIL latch_overwrite_flag got=%h exp=00", got); failures++; end
    endtask
`else
    task automatic test_fifo();
        logic [7:0] exp_q[$];
        logic [7:0] got;
        exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC4};
        for (int i = 0; i < 5; i++) strobe_key(7'(7'h41 + i));
        for (int i = 0; i < 5; i++) begin
            read_reg(2'd0, 1'b1, got);
            checks++;
            if (got !== exp_q[i]) begin
                $display("FAIL fifo_read%0d got=%h exp=%h", i, got, exp_q[i]); failures++;
            end
            if (i == 3) begin
                read_reg(2'd1, 1'b1, got);
                checks++;
                if (got !== 8'h00) begin $display("FAIL fifo_flag_empty got=%h exp=00", got); failures++; end
            end
        end
    endtask
`endif

    task automatic test_display();
        logic [7:0] got;
        disp_ready = 1'b0;
        write_reg(2'd2, 8'h8D);
        checks++;
        if (disp_data !== 7'h0D || disp_valid !== 1'b1) begin
            $display("FAIL dsp_write got=%b/%h exp=1/0D", disp_valid, disp_data); failures++;
        end
        read_reg(2'd2, 1'b1, got);
        checks++;
        if (got !== 8'h8D) begin $display("FAIL dsp_read_pending got=%h exp=8D", got); failures++; end
        disp_ready = 1'b1;
        @(posedge clk); #1;
        disp_ready = 1'b0;
        checks++;
        if (disp_valid !== 1'b0) begin $display("FAIL dsp_transfer got=%b exp=0", disp_valid); failures++; end
        read_reg(2'd2, 1'b1, got);
        checks++;
        if (got !== 8'h0D) begin $display("FAIL dsp_read_done got=%h exp=0D", got); failures++; end
        write_reg(2'd3, 8'hFF);
        read_reg(2'd3, 1'b1, got);
        checks++;
        if (got !== 8'h7F) begin $display("FAIL dspcr_rw got=%h exp=7F", got); failures++; end
    endtask

    task automatic test_back_to_back();
        write_reg(2'd2, 8'h11);
        write_reg(2'd2, 8'h22);
        checks++;
        if (disp_data !== 7'h22 || disp_valid !== 1'b1) begin
            $display("FAIL dsp_overwrite got=%b/%h exp=1/22", disp_valid, disp_data); failures++;
        end
        disp_ready = 1'b1;
        write_reg(2'd2, 8'h43);
        checks++;
        if (disp_data !== 7'h43 || disp_valid !== 1'b1) begin
            $display("FAIL dsp_write_wins got=%b/%h exp=1/43", disp_valid, disp_data); failures++;
        end
        @(posedge clk); #1;
        disp_ready = 1'b0;
        checks++;
        if (disp_valid !== 1'b0 || disp_data !== 7'h43) begin
            $display("FAIL dsp_final_transfer got=%b/%h exp=0/43", disp_valid, disp_data); failures++;
        end
    endtask

    initial begin
        test_reset();
        test_keyboard();
        test_kbd_same_edge();
`ifndef APPLE1_PIA_KBD_FIFO_EN
        test_latch_overwrite();
`else
        test_fifo();
`endif
        test_display();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apple1_pia.md
# apple1_pia

Keyboard/display peripheral that answers the 6502 core's bus at $D010–$D013, the Apple-1 PIA register window. It consumes the core's address, write data and write strobe, and returns read data to the core's `dbi`. Its far side accepts ASCII key strobes from the keyboard front end and hands display characters to the terminal/video stage over a valid/ready handshake. Bus side effects are qualified by the same `enable` that gates the CPU.

## Interface
- `FIFO_DEPTH`, 4, keyboard buffer entries when `APPLE1_PIA_KBD_FIFO_EN` is defined; power of two, 2..16.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  CPU clock enable; bus side effects occur only when high.
- `cs`  in  1  chip select, decoded upstream for $D010–$D013.
- `addr`  in  2  register index from `ab[1:0]`.
- `we`  in  1  CPU write strobe, active high.
- `din`  in  8  CPU write data from `dbo`.
- `dout`  out  8  read data to CPU `dbi`; combinational from registers.
- `kbd_data`  in  7  ASCII key code.
- `kbd_strobe`  in  1  one-cycle key-arrival pulse; sampled every `clk`, independent of `enable`.
- `disp_data`  out  7  character to display.
- `disp_valid`  out  1  display character pending.
- `disp_ready`  in  1  display consumer accepts when high with `disp_valid`.

## Operation
- Bus access: `acc = enable & cs`. Write when `acc & we`; read side effect when `acc & ~we`.
- Key capture: on `kbd_strobe`, fold lowercase: if code is in $61–$7A, subtract $20. Store the 7-bit result.
- Register map:
  - 0 KBD: read `{1, key[6:0]}` (head key). A read with side effect clears `kbd_flag` (latch mode) or pops one entry (FIFO mode). Writes are ignored.
  - 1 KBDCR: read `{kbd_flag, kcr[6:0]}`. A write stores `din[6:0]`; `kbd_flag` is read-only.
  - 2 DSP: a write loads `disp_data <= din[6:0]` and sets `disp_valid`. A read returns `{disp_valid, disp_data}`. A write while `disp_valid` is high overwrites the data and `disp_valid` stays high.
  - 3 DSPCR: read `{1'b0, dcr[6:0]}`; a write stores `din[6:0]`.
- `dout` is $00 when `cs` is low.
- Display handshake: transfer occurs on a cycle with `disp_valid & disp_ready`; `disp_valid` clears on the next edge. If a DSP write and a transfer fall on the same edge, the write wins: new data is loaded and `disp_valid` stays 1.
- Latch mode, `kbd_flag` set:
  - A new strobe overwrites the key.
  - A strobe on the same edge as a KBD read leaves the flag set and the new key stored.
- Reset: `dout` $00; `disp_valid` 0; `disp_data` 0; `kcr` = `dcr` = 0; `kbd_flag` 0; FIFO empty with pointers at 0.

## Timing
- Key strobe at edge N: the key is visible in `dout` (KBD/KBDCR) after edge N.
- DSP write at edge N: `disp_valid`=1 and `disp_data` are valid after edge N.
- Transfer at edge M: `disp_valid`=0 after edge M; a DSP read after that edge shows bit7=0.
- All read side effects occur on the `enable`-qualified edge only. Reads while `enable`=0 are side-effect free.

## Configuration
- `APPLE1_PIA_KBD_FIFO_EN` defined: keyboard path is a FIFO_DEPTH-entry FIFO.
  - `kbd_flag` = not empty; KBD reads the head entry.
  - Push when full drops the new key.
  - Push and pop on the same edge: both are performed and the count is unchanged. When empty, only the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Not defined: single-entry latch with overwrite, as described under Operation.

## Test plan
- Reset, then read all four registers with `enable`=1: `dout` = $80, $00, $00, $00. Drive `cs`=0: `dout` = $00.
- Strobe $61 ('a'), then read KBDCR: $80. Read KBD: $C1. Read KBDCR again: $00.
- Write $8D to DSP with `disp_ready`=0: `disp_data`=$0D, `disp_valid`=1, DSP read = $8D. Raise `disp_ready`: `disp_valid`=0 one edge later, DSP read = $0D.
- DSP write and transfer on the same edge: `disp_valid` stays 1 with the new data.
- Latch mode: KBD read and strobe of $42 on the same edge: KBDCR = $80, KBD = $C2.
- FIFO mode, depth 4: strobe 'A','B','C','D','E', then read KBD five times → $C1, $C2, $C3, $C4, $C4, with `kbd_flag` = 0 after the fourth read. 'E' is dropped, and the fifth read of an empty FIFO returns the stale head and pops nothing.
